// File: rtl/sequence_scan_controller.sv
// Streams a latched word MSB-first into a serial sequence detector and
// collects the detector's Moore output into match statistics.
module sequence_scan_controller #(
    parameter int WORD_W = 16,
    parameter int CNT_W  = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [WORD_W-1:0] data_in,
    input  logic              det_in,
    output logic              det_w,
    output logic              det_resetn,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [CNT_W-1:0]  match_count,
    output logic [CNT_W-1:0]  first_pos
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_W - 1);

    state_t              state;
    state_t              next_state;
    logic [WORD_W-1:0]   shreg;
    logic [CNT_W-1:0]    bit_cnt;
    logic                sample;
    logic                hit;
    logic [CNT_W-1:0]    hit_index;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_SHIFT;
            S_SHIFT: if (bit_cnt == LAST) next_state = S_DRAIN;
            S_DRAIN: next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        det_w      = 1'b0;
        det_resetn = 1'b0;
        case (state)
            S_SHIFT: begin
                det_w      = shreg[WORD_W-1];
                det_resetn = 1'b1;
            end
            S_DRAIN: det_resetn = 1'b1;
            default: begin
                det_w      = 1'b0;
                det_resetn = 1'b0;
            end
        endcase
    end

    // The detector output lags the fed bit by one cycle, so the sample taken
    // at an edge belongs to the previous bit; DRAIN picks up the final bit.
    always_comb begin
        sample    = ((state == S_SHIFT) && (bit_cnt != '0)) || (state == S_DRAIN);
        hit       = sample && det_in;
        hit_index = (state == S_DRAIN) ? LAST : bit_cnt - CNT_W'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shreg       <= '0;
            bit_cnt     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            found       <= 1'b0;
            match_count <= '0;
            first_pos   <= '0;
        end else begin
            busy <= (next_state == S_SHIFT) || (next_state == S_DRAIN);
            done <= (next_state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        shreg       <= data_in;
                        bit_cnt     <= '0;
                        found       <= 1'b0;
                        match_count <= '0;
                        first_pos   <= '0;
                    end
                end
                S_SHIFT, S_DRAIN: begin
                    if (state == S_SHIFT) begin
                        shreg   <= shreg << 1;
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                    if (hit) begin
                        if (match_count != '1) begin
                            match_count <= match_count + CNT_W'(1);
                        end
                        if (!found) begin
                            found     <= 1'b1;
                            first_pos <= hit_index;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sequence_scan_controller.sv
// Bench for sequence_scan_controller with a behavioural 1111/1101 detector
// and a word-level reference for match statistics and run timing.
module tb_sequence_scan_controller;

    logic        clock;
    logic        reset;
    logic        start;
    logic [15:0] data_in;
    logic        det_in;
    logic        det_w;
    logic        det_resetn;
    logic        busy;
    logic        done;
    logic        found;
    logic [4:0]  match_count;
    logic [4:0]  first_pos;

    int n_vec = 0;
    int n_err = 0;

    sequence_scan_controller #(.WORD_W(16), .CNT_W(5)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .data_in     (data_in),
        .det_in      (det_in),
        .det_w       (det_w),
        .det_resetn  (det_resetn),
        .busy        (busy),
        .done        (done),
        .found       (found),
        .match_count (match_count),
        .first_pos   (first_pos)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Detector: registered history, Moore output on ...1111 / ...1101.
    logic [3:0] hist;
    always_ff @(posedge clock) begin
        if (!det_resetn) hist <= '0;
        else             hist <= {hist[2:0], det_w};
    end
    assign det_in = (hist == 4'b1111) || (hist == 4'b1101);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scan the word MSB-first through a 4-bit window; nbits limits the scan.
    function automatic void model(input logic [15:0] w, input int nbits,
                                  output int cnt, output int fp, output int f);
        logic [3:0] win;
        win = '0; cnt = 0; fp = 0; f = 0;
        for (int i = 0; i < nbits; i++) begin
            win = {win[2:0], w[15-i]};
            if (win == 4'hF || win == 4'hD) begin
                if (cnt < 31) cnt++;
                if (f == 0) begin
                    f  = 1;
                    fp = i;
                end
            end
        end
    endfunction

    task automatic check_results(input string tag, input logic [15:0] w);
        int ecnt, efp, ef;
        model(w, 16, ecnt, efp, ef);
        check({tag, " found"}, found, ef);
        check({tag, " match_count"}, match_count, ecnt);
        check({tag, " first_pos"}, first_pos, efp);
    endtask

    task automatic run(input string tag, input logic [15:0] w, input bit poke);
        int lat, ndone, rhi, bhi;
        logic [15:0] cap;
        logic drain_w;
        @(negedge clock);
        data_in = w;
        start   = 1'b1;
        @(posedge clock);
        #1;
        start   = 1'b0;
        data_in = ~w;
        lat = -1; ndone = 0; rhi = 0; bhi = 0; cap = '0; drain_w = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clock);
            if (poke) start = (i == 5 || i == 16 || i == 18);
            if (det_resetn) rhi++;
            if (busy) bhi++;
            if (i <= 16) cap[16-i] = det_w;
            if (i == 17) drain_w = det_w;
            if (done) begin
                ndone++;
                if (lat < 0) lat = i - 1;
            end
        end
        start = 1'b0;
        check({tag, " latency"}, lat, 17);
        check({tag, " done pulses"}, ndone, 1);
        check({tag, " det_resetn high cycles"}, rhi, 17);
        check({tag, " busy cycles"}, bhi, 17);
        check({tag, " det_w stream"}, cap, w);
        check({tag, " det_w drain"}, drain_w, 0);
        check_results(tag, w);
    endtask

    initial begin
        int ecnt, efp, ef, lat, ndone;
        logic [15:0] w;

        reset = 1'b1; start = 1'b0; data_in = '0;
        repeat (2) @(negedge clock);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst found", found, 0);
        check("rst match_count", match_count, 0);
        check("rst first_pos", first_pos, 0);
        check("rst det_w", det_w, 0);
        check("rst det_resetn", det_resetn, 0);
        reset = 1'b0;
        @(negedge clock);

        run("d000", 16'hD000, 1'b0);
        run("ffff", 16'hFFFF, 1'b0);
        run("dddd", 16'hDDDD, 1'b1);
        run("0000", 16'h0000, 1'b0);

        // Start held high: back-to-back runs with one IDLE cycle between.
        @(negedge clock);
        data_in = 16'hFFFF;
        start   = 1'b1;
        @(posedge clock);
        #1 data_in = 16'hDDDD;
        lat = -1;
        for (int i = 1; i <= 30 && lat < 0; i++) begin
            @(negedge clock);
            if (done) lat = i - 1;
        end
        check("held run1 latency", lat, 17);
        @(negedge clock);
        check("held idle busy", busy, 0);
        check("held idle done", done, 0);
        check_results("held run1", 16'hFFFF);
        @(negedge clock);
        check("held run2 busy", busy, 1);
        check("held run2 cleared count", match_count, 0);
        check("held run2 cleared found", found, 0);
        start = 1'b0;
        lat = -1;
        for (int i = 2; i <= 30 && lat < 0; i++) begin
            @(negedge clock);
            if (done) lat = i - 1;
        end
        check("held run2 latency", lat, 17);
        check_results("held run2", 16'hDDDD);
        repeat (2) @(negedge clock);

        // Asynchronous reset in the middle of a run.
        @(negedge clock);
        data_in = 16'hFFFF;
        start   = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (9) @(negedge clock);
        model(16'hFFFF, 7, ecnt, efp, ef);
        check("midrst partial count", match_count, ecnt);
        #2 reset = 1'b1;
        #1;
        check("midrst busy", busy, 0);
        check("midrst done", done, 0);
        check("midrst found", found, 0);
        check("midrst match_count", match_count, 0);
        check("midrst first_pos", first_pos, 0);
        check("midrst det_resetn", det_resetn, 0);
        check("midrst det_w", det_w, 0);
        ndone = 0;
        @(negedge clock);
        if (done) ndone++;
        reset = 1'b0;
        repeat (20) begin
            @(negedge clock);
            if (done) ndone++;
        end
        check("midrst no done", ndone, 0);
        run("after reset d000", 16'hD000, 1'b0);

        for (int k = 0; k < 20; k++) begin
            w = 16'($urandom);
            if (k % 4 == 0) w = w | 16'hD0D0;
            run($sformatf("rand%0d", k), w, k[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, got running expected finished");
        $fatal(1);
    end

endmodule
